// File: rtl/shift_deserializer.sv
// LSB-first serial-to-parallel receiver with a valid/ready output port.
// A frame completes on the WIDTH-th strobe. If the output slot cannot take the word, it is dropped and overrun is set.
module shift_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             shift_rst,
    input  logic             start,
    input  logic             bit_en,
    input  logic             ser_in,
    input  logic             abort,
    input  logic             out_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] word;
    logic             done;
    logic             take;

    assign word = {ser_in, sreg[WIDTH-1:1]};
    assign done = (state == SHIFT) && !abort && bit_en && (cnt == CW'(WIDTH - 1));
    // A completing frame may reuse the slot when the consumer empties it in the same cycle.
    assign take = done && (!out_valid || out_ready);

    always_ff @(posedge clk or posedge shift_rst) begin
        if (shift_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        sreg  <= '0;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        sreg  <= '0;
                    end else if (bit_en) begin
                        sreg <= word;
                        if (done) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (take) begin
                data_out  <= word;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // Set wins over clear.
            if (done && !take)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: handshake, overrun, abort, async reset, loopback.
module tb_shift_deserializer;
    logic       clk = 1'b0;
    logic       shift_rst, start, bit_en_r, ser_r, abort, out_ready, clr_ovr;
    logic [7:0] data_out;
    logic       out_valid, busy, overrun;

    // Model of the upstream right-shifting load/shift register.
    logic       loop_mode, sh_load, sh_en;
    logic [7:0] sh_din, q;
    logic       ser_w, bit_en_w;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (sh_load) q <= sh_din;
        else if (sh_en) q <= {1'b0, q[7:1]};

    assign ser_w    = loop_mode ? q[0]  : ser_r;
    assign bit_en_w = loop_mode ? sh_en : bit_en_r;

    shift_deserializer #(.WIDTH(8)) dut (
        .clk(clk), .shift_rst(shift_rst), .start(start), .bit_en(bit_en_w),
        .ser_in(ser_w), .abort(abort), .out_ready(out_ready), .clr_ovr(clr_ovr),
        .data_out(data_out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    task automatic send_bit(input logic b, input logic rdy, input logic clr);
        @(negedge clk);
        bit_en_r = 1'b1; ser_r = b; out_ready = rdy; clr_ovr = clr;
        @(negedge clk);
        bit_en_r = 1'b0; out_ready = 1'b0; clr_ovr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Ends at the negedge just after the completing edge, unless the gap is used.
    task automatic send_word(input logic [7:0] w, input logic rdy_last, input logic clr_last);
        for (int i = 0; i < 8; i++) begin
            if (i < 7) begin
                send_bit(w[i], 1'b0, 1'b0);
            end else begin
                @(negedge clk);
                bit_en_r = 1'b1; ser_r = w[i]; out_ready = rdy_last; clr_ovr = clr_last;
                @(negedge clk);
                bit_en_r = 1'b0; out_ready = 1'b0; clr_ovr = 1'b0;
            end
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        shift_rst = 1'b1;
        #12;
        checks++; if (data_out !== 8'h00) $display("FAIL reset_data got=%h exp=00", data_out); else passes++;
        checks++; if ({out_valid, busy, overrun} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {out_valid, busy, overrun}); else passes++;
        @(negedge clk);
        shift_rst = 1'b0;
    endtask

    task automatic test_frame_a5();
        pulse_start();
        checks++; if (busy !== 1'b1) $display("FAIL a5_busy_start got=%b exp=1", busy); else passes++;
        send_word(8'hA5, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) $display("FAIL a5_valid got=%b exp=1", out_valid); else passes++;
        checks++; if (data_out !== 8'hA5) $display("FAIL a5_data got=%h exp=a5", data_out); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL a5_busy_end got=%b exp=0", busy); else passes++;
        drain();
        checks++; if (out_valid !== 1'b0) $display("FAIL a5_drain got=%b exp=0", out_valid); else passes++;
    endtask

    task automatic test_backpressure();
        pulse_start(); send_word(8'h3C, 1'b0, 1'b0);
        checks++; if (data_out !== 8'h3C) $display("FAIL bp_first got=%h exp=3c", data_out); else passes++;
        pulse_start(); send_word(8'h81, 1'b0, 1'b0);
        checks++; if (data_out !== 8'h3C) $display("FAIL bp_hold got=%h exp=3c", data_out); else passes++;
        checks++; if ({out_valid, overrun} !== 2'b11) $display("FAIL bp_ovr got=%b exp=11", {out_valid, overrun}); else passes++;
        @(negedge clk); clr_ovr = 1'b1;
        @(negedge clk); clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b0) $display("FAIL bp_clr got=%b exp=0", overrun); else passes++;
        // Drop and clear in the same cycle: the set must win.
        pulse_start(); send_word(8'h99, 1'b0, 1'b1);
        checks++; if (overrun !== 1'b1) $display("FAIL bp_set_wins got=%b exp=1", overrun); else passes++;
        checks++; if (data_out !== 8'h3C) $display("FAIL bp_hold2 got=%h exp=3c", data_out); else passes++;
        @(negedge clk); clr_ovr = 1'b1;
        @(negedge clk); clr_ovr = 1'b0;
    endtask

    task automatic test_accept_on_completion();
        pulse_start(); send_word(8'h81, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1) $display("FAIL aoc_valid got=%b exp=1", out_valid); else passes++;
        checks++; if (data_out !== 8'h81) $display("FAIL aoc_data got=%h exp=81", data_out); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL aoc_ovr got=%b exp=0", overrun); else passes++;
        drain();
    endtask

    task automatic test_abort();
        pulse_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++; if ({busy, out_valid, overrun} !== 3'b000) $display("FAIL abort_flags got=%b exp=000", {busy, out_valid, overrun}); else passes++;
        pulse_start(); send_word(8'hFF, 1'b0, 1'b0);
        checks++; if (data_out !== 8'hFF || out_valid !== 1'b1) $display("FAIL abort_next got=%h/%b exp=ff/1", data_out, out_valid); else passes++;
    endtask

    task automatic test_async_reset();
        // FF is left valid so the reset has something to clear.
        pulse_start();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) $display("FAIL ar_busy_pre got=%b exp=1", busy); else passes++;
        #2 shift_rst = 1'b1;
        #1;
        checks++; if ({data_out, out_valid, busy, overrun} !== 11'd0) $display("FAIL ar_clear got=%h/%b%b%b exp=00/000", data_out, out_valid, busy, overrun); else passes++;
        @(negedge clk); shift_rst = 1'b0;
        pulse_start(); send_word(8'h0F, 1'b0, 1'b0);
        checks++; if (data_out !== 8'h0F || out_valid !== 1'b1) $display("FAIL ar_next got=%h/%b exp=0f/1", data_out, out_valid); else passes++;
        drain();
    endtask

    task automatic test_loopback();
        loop_mode = 1'b1;
        @(negedge clk); sh_din = 8'h5A; sh_load = 1'b1;
        @(negedge clk); sh_load = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0; sh_en = 1'b1;
        for (int i = 0; i < 8; i++) @(negedge clk);
        sh_en = 1'b0;
        checks++; if (data_out !== 8'h5A || out_valid !== 1'b1) $display("FAIL loop_data got=%h/%b exp=5a/1", data_out, out_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL loop_busy got=%b exp=0", busy); else passes++;
        loop_mode = 1'b0;
        drain();
    endtask

    task automatic test_start_with_bit();
        @(negedge clk); start = 1'b1; bit_en_r = 1'b1; ser_r = 1'b1;
        @(negedge clk); start = 1'b0; bit_en_r = 1'b0;
        send_word(8'h12, 1'b0, 1'b0);
        checks++; if (data_out !== 8'h12 || out_valid !== 1'b1) $display("FAIL swb_data got=%h/%b exp=12/1", data_out, out_valid); else passes++;
        drain();
    endtask

    task automatic test_ready_idle();
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        checks++; if ({out_valid, data_out} !== {1'b0, 8'h12}) $display("FAIL ready_idle got=%b/%h exp=0/12", out_valid, data_out); else passes++;
    endtask

    initial begin
        shift_rst = 1'b0; start = 1'b0; bit_en_r = 1'b0; ser_r = 1'b0; abort = 1'b0;
        out_ready = 1'b0; clr_ovr = 1'b0; loop_mode = 1'b0; sh_load = 1'b0; sh_en = 1'b0;
        sh_din = 8'h00;
        test_reset();
        test_frame_a5();
        test_backpressure();
        test_accept_on_completion();
        test_abort();
        test_async_reset();
        test_loopback();
        test_start_with_bit();
        test_ready_idle();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
